// File: rtl/if_pkg.sv
// if_pkg: shared widths, opcode field bounds, queue entry type and fetch state enum
package if_pkg;
  localparam int PC_W = 16;
  localparam int INST_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  typedef enum logic {IF_RUN, IF_HALTED} if_state_e;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory, decode and control signals of the fetch stage
interface if_fetch_stage_if
  import if_pkg::*;
#(
  parameter int PC_W = if_pkg::PC_W,
  parameter int INST_W = if_pkg::INST_W
);
  logic imem_rd_en;
  logic [PC_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic id_ready;
  logic id_valid;
  logic [INST_W-1:0] id_inst;
  logic [PC_W-1:0] id_pc;
  logic [5:0] id_opcode;
  logic redirect;
  logic [PC_W-1:0] redirect_pc;
  logic halt;
  logic fetch_idle;
  modport master (
    output imem_rd_en, imem_addr, id_valid, id_inst, id_pc, id_opcode, fetch_idle,
    input imem_rdata, id_ready, redirect, redirect_pc, halt
  );
  modport slave (
    input imem_rd_en, imem_addr, id_valid, id_inst, id_pc, id_opcode, fetch_idle,
    output imem_rdata, id_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/if_inst_queue.sv
// if_inst_queue: small synchronous FIFO of fetched {pc, inst} entries with flush
module if_inst_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = iq_entry_t,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  T wdata_i,
  output T rdata_o,
  output logic empty_o,
  output logic [AW:0] count_o
);
  logic [AW:0] wp_q, rp_q;
  T mem_q [DEPTH];
  logic full, do_push, do_pop;
  assign empty_o = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign count_o = wp_q - rp_q;
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full || do_pop);
  assign rdata_o = mem_q[rp_q[AW-1:0]];
  // pointers: flush empties the queue, otherwise advance on push/pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_q + (AW+1)'(do_push);
      rp_q <= rp_q + (AW+1)'(do_pop);
    end
  // storage needs no reset; entries are only read while counted valid
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, fetch FSM and credit-based issue into a 1-cycle imem; optional IF_PERF_CNT_EN perf counters
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int PC_W = if_pkg::PC_W,
  parameter int INST_W = if_pkg::INST_W,
  parameter int IQ_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  if_fetch_stage_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_starve_cnt
`endif
);
  localparam int CW = $clog2(IQ_DEPTH) + 1;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;
  if_state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, inflight_pc_q;
  logic inflight_q, issue, push, pop, empty;
  logic [CW-1:0] count;
  logic [CW:0] credit;
  entry_t head;
  // a word returning during a redirect belongs to the old path and is dropped
  assign push = inflight_q && !bus.redirect;
  assign pop = !empty && bus.id_ready;
  if_inst_queue #(.DEPTH(IQ_DEPTH), .T(entry_t)) u_iq (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .flush_i(bus.redirect),
    .wdata_i('{pc: inflight_pc_q, inst: bus.imem_rdata}),
    .rdata_o(head),
    .empty_o(empty),
    .count_o(count)
  );
  // issue only while the queue can absorb the word after this cycle's pop and in-flight return
  always_comb begin
    credit = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight_q);
    issue = !rst && state_q == IF_RUN && !bus.redirect && !bus.halt && credit < (CW+1)'(IQ_DEPTH);
    state_d = bus.redirect ? IF_RUN : bus.halt ? IF_HALTED : state_q;
    pc_d = bus.redirect ? bus.redirect_pc : issue ? pc_q + 1'b1 : pc_q;
  end
  // fetch state, PC and the single outstanding request with its PC tag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IF_RUN;
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
    end
  assign bus.imem_rd_en = issue;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid = !empty;
  assign bus.id_inst = empty ? '0 : head.inst;
  assign bus.id_pc = empty ? '0 : head.pc;
  assign bus.id_opcode = bus.id_inst[OPC_MSB:OPC_LSB];
  assign bus.fetch_idle = state_q == IF_HALTED && empty && !inflight_q;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, starve_cnt_q;
  // saturating counts of instructions handed to decode and RUN cycles decode waited on fetch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_cnt_q <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (pop && ~&fetch_cnt_q) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == IF_RUN && empty && bus.id_ready && ~&starve_cnt_q) starve_cnt_q <= starve_cnt_q + 32'd1;
    end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_starve_cnt = starve_cnt_q;
`endif
endmodule
